// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the instruction format and sign-extended immediate,
// registers the result one cycle later behind a main/skid output buffer with flush.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 64,
    parameter bit          SHIFT_BJ = 1'b1,
    parameter int unsigned TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam bit Rv64 = (XLEN == 64);

    entry_t dec, main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   accept, transfer, s;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

    assign s = in_instr[31];

    // All candidates are built at 64 bits and truncated once to XLEN.
    always_comb begin
        imm_i = {{52{s}}, in_instr[31:20]};
        imm_s = {{52{s}}, in_instr[31:25], in_instr[11:7]};
        imm_u = {{32{s}}, in_instr[31:12], 12'b0};
        if (SHIFT_BJ) begin
            imm_b = {{52{s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            imm_j = {{44{s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        end else begin
            imm_b = {{53{s}}, in_instr[7], in_instr[30:25], in_instr[11:8]};
            imm_j = {{45{s}}, in_instr[19:12], in_instr[20], in_instr[30:21]};
        end
    end

    always_comb begin
        imm_sel     = '0;
        dec.fmt     = FmtR;
        dec.illegal = 1'b0;
        dec.tag     = in_tag;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.fmt = FmtI;
                imm_sel = imm_i;
            end
            7'b0011011: begin
                if (Rv64) begin
                    dec.fmt = FmtI;
                    imm_sel = imm_i;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0100011: begin
                dec.fmt = FmtS;
                imm_sel = imm_s;
            end
            7'b1100011: begin
                dec.fmt = FmtB;
                imm_sel = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FmtU;
                imm_sel = imm_u;
            end
            7'b1101111: begin
                dec.fmt = FmtJ;
                imm_sel = imm_j;
            end
            7'b0110011: dec.fmt = FmtR;
            7'b0111011: dec.illegal = !Rv64;
            default:    dec.illegal = 1'b1;
        endcase
        dec.imm = imm_sel[XLEN-1:0];
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign transfer = main_valid_q & out_ready;

    // Flush wins over everything; the skid only fills when main is stalled.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (transfer) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || transfer) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (transfer) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (RV64 shifted, RV32, RV64 unshifted) share
// stimulus and are compared against an arithmetic decode model and a queue-based FIFO model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [7:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        rdy [3];
    logic        vld [3];
    logic        ill [3];
    logic [2:0]  fmt [3];
    logic [7:0]  tg  [3];
    logic [63:0] imm_a, imm_c;
    logic [31:0] imm_b;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [39:0] q [$];

    typedef struct packed {
        logic        ill;
        logic [2:0]  fmt;
        logic [63:0] imm;
    } ref_t;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .SHIFT_BJ(1'b1), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld[0]), .out_ready(out_ready),
        .out_imm(imm_a), .out_fmt(fmt[0]), .out_illegal(ill[0]), .out_tag(tg[0])
    );

    imm_gen_pipe #(.XLEN(32), .SHIFT_BJ(1'b1), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld[1]), .out_ready(out_ready),
        .out_imm(imm_b), .out_fmt(fmt[1]), .out_illegal(ill[1]), .out_tag(tg[1])
    );

    imm_gen_pipe #(.XLEN(64), .SHIFT_BJ(1'b0), .TAG_W(8)) u_dut64u (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld[2]), .out_ready(out_ready),
        .out_imm(imm_c), .out_fmt(fmt[2]), .out_illegal(ill[2]), .out_tag(tg[2])
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Immediate as a signed integer offset assembled from the field weights.
    function automatic ref_t ref_decode(input logic [31:0] ins, input bit rv64, input bit shift);
        ref_t   r;
        longint v;
        r = '0;
        v = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin r.fmt = 3'd1; v = longint'($signed(ins[31:20])); end
            7'h1B: begin
                if (rv64) begin r.fmt = 3'd1; v = longint'($signed(ins[31:20])); end
                else r.ill = 1'b1;
            end
            7'h23: begin r.fmt = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin
                r.fmt = 3'd3;
                v = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (!shift) v = v / 2;
            end
            7'h37, 7'h17: begin r.fmt = 3'd4; v = longint'($signed(ins[31:12])) * 4096; end
            7'h6F: begin
                r.fmt = 3'd5;
                v = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
                    + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (!shift) v = v / 2;
            end
            7'h33: r.ill = 1'b0;
            7'h3B: r.ill = !rv64;
            default: r.ill = 1'b1;
        endcase
        r.imm = rv64 ? 64'(v) : {32'b0, v[31:0]};
        return r;
    endfunction

    task automatic check_all();
        ref_t        e;
        logic [63:0] got;
        logic [39:0] h;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("in_ready[%0d]", i), 64'(rdy[i]), 64'(q.size() < 2));
            check_eq($sformatf("out_valid[%0d]", i), 64'(vld[i]), 64'(q.size() != 0));
            if (q.size() != 0) begin
                h   = q[0];
                e   = ref_decode(h[31:0], i != 1, i != 2);
                got = (i == 0) ? imm_a : (i == 1) ? {32'b0, imm_b} : imm_c;
                check_eq($sformatf("out_imm[%0d]", i), got, e.imm);
                check_eq($sformatf("out_fmt[%0d]", i), 64'(fmt[i]), 64'(e.fmt));
                check_eq($sformatf("out_illegal[%0d]", i), 64'(ill[i]), 64'(e.ill));
                check_eq($sformatf("out_tag[%0d]", i), 64'(tg[i]), 64'(h[39:32]));
            end
        end
    endtask

    // Called at a negedge: drive, let one rising edge pass, update the model, check outputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic [7:0] t,
                        input logic r, input logic fl);
        bit acc;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = t;
        out_ready = r;
        flush     = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            acc = v && (q.size() < 2);
            if (q.size() != 0 && r) void'(q.pop_front());
            if (acc) q.push_back({t, ins});
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            check_eq({name, "_valid"}, 64'(vld[i]), 64'd0);
            check_eq({name, "_fmt"}, 64'(fmt[i]), 64'd0);
            check_eq({name, "_illegal"}, 64'(ill[i]), 64'd0);
            check_eq({name, "_tag"}, 64'(tg[i]), 64'd0);
        end
        check_eq({name, "_imm64"}, imm_a, 64'd0);
        check_eq({name, "_imm32"}, {32'b0, imm_b}, 64'd0);
        check_eq({name, "_imm64u"}, imm_c, 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [6:0] ops [14] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h33, 7'h3B, 7'h00, 7'h7F, 7'h0F};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;

        @(negedge clk);
        check_zero("init");
        rst_n = 1'b1;
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        check_eq("ready_after_reset", 64'(rdy[0]), 64'd1);

        step(1'b1, 32'hFFF00093, 8'h10, 1'b1, 1'b0);
        check_eq("addi_imm", imm_a, 64'hFFFFFFFFFFFFFFFF);
        check_eq("addi_fmt", 64'(fmt[0]), 64'd1);
        check_eq("addi_ill", 64'(ill[0]), 64'd0);
        step(1'b1, 32'hFE513C23, 8'h11, 1'b1, 1'b0);
        check_eq("sd_imm", imm_a, 64'hFFFFFFFFFFFFFFF8);
        check_eq("sd_fmt", 64'(fmt[0]), 64'd2);
        step(1'b1, 32'h800000B7, 8'h12, 1'b1, 1'b0);
        check_eq("lui_neg_imm", imm_a, 64'hFFFFFFFF80000000);
        check_eq("lui_fmt", 64'(fmt[0]), 64'd4);
        step(1'b1, 32'h123450B7, 8'h13, 1'b1, 1'b0);
        check_eq("lui_pos_imm", imm_a, 64'h0000000012345000);
        step(1'b1, 32'hFE000EE3, 8'h14, 1'b1, 1'b0);
        check_eq("beq_shift_imm", imm_a, 64'hFFFFFFFFFFFFFFFC);
        check_eq("beq_noshift_imm", imm_c, 64'hFFFFFFFFFFFFFFFE);
        check_eq("beq_fmt", 64'(fmt[2]), 64'd3);
        step(1'b1, 32'h0010009B, 8'h15, 1'b1, 1'b0);
        check_eq("addiw32_ill", 64'(ill[1]), 64'd1);
        check_eq("addiw32_imm", {32'b0, imm_b}, 64'd0);
        check_eq("addiw32_fmt", 64'(fmt[1]), 64'd0);
        check_eq("addiw32_valid", 64'(vld[1]), 64'd1);
        check_eq("addiw64_imm", imm_a, 64'd1);
        check_eq("addiw64_fmt", 64'(fmt[0]), 64'd1);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // Back-pressure: tags 1 and 2 fill main and skid, tag 3 is held off.
        step(1'b1, 32'h00100093, 8'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 8'd2, 1'b0, 1'b0);
        check_eq("bp_ready_full", 64'(rdy[0]), 64'd0);
        step(1'b1, 32'h00300093, 8'd3, 1'b0, 1'b0);
        check_eq("bp_hold_tag", 64'(tg[0]), 64'd1);
        step(1'b1, 32'h00300093, 8'd3, 1'b1, 1'b0);
        check_eq("bp_tag2", 64'(tg[0]), 64'd2);
        step(1'b1, 32'h00300093, 8'd3, 1'b1, 1'b0);
        check_eq("bp_tag3", 64'(tg[0]), 64'd3);
        check_eq("bp_tag3_valid", 64'(vld[0]), 64'd1);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        check_eq("bp_drained", 64'(vld[0]), 64'd0);

        // Flush with both entries full, then flush against an otherwise-accepted instruction.
        step(1'b1, 32'h00400093, 8'd4, 1'b0, 1'b0);
        step(1'b1, 32'h00500093, 8'd5, 1'b0, 1'b0);
        step(1'b1, 32'h00600093, 8'd6, 1'b0, 1'b1);
        check_eq("flush_valid", 64'(vld[0]), 64'd0);
        check_eq("flush_ready", 64'(rdy[0]), 64'd1);
        step(1'b1, 32'h00700093, 8'd7, 1'b1, 1'b1);
        check_eq("flush_beats_accept", 64'(vld[0]), 64'd0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        check_eq("flush_no_ghost", 64'(vld[0]), 64'd0);

        // Reset pulsed mid-stall.
        step(1'b1, 32'h00800093, 8'd8, 1'b0, 1'b0);
        step(1'b1, 32'h00900093, 8'd9, 1'b0, 1'b0);
        in_valid = 1'b0;
        pulse_reset();
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        check_eq("rst_ready", 64'(rdy[0]), 64'd1);
        check_eq("rst_valid", 64'(vld[0]), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            r  = $urandom();
            op = ($urandom_range(0, 7) == 0) ? r[6:0] : ops[$urandom_range(0, 13)];
            step($urandom_range(0, 3) != 0, {r[31:7], op}, 8'($urandom()),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
